// File: rtl/nios2_oci_tm_fifo_drain.sv
// Trace-message receive buffer: admits 0-3 messages per cycle (itm, atm, dtm order) into a
// circular store and drains one per cycle over valid/ready; groups that do not fit are dropped whole.
module nios2_oci_tm_fifo_drain #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [35:0]   itm,
  input  logic          itm_valid,
  input  logic [35:0]   atm,
  input  logic          atm_valid,
  input  logic [35:0]   dtm,
  input  logic          dtm_valid,
  input  logic          trc_clear,
  output logic [35:0]   tr_data,
  output logic          tr_valid,
  input  logic          tr_ready,
  output logic [AW:0]   fifo_count,
  output logic          tm_overflow
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [35:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic [1:0]    grp_n;
  logic [AW:0]   grp_n_w;
  logic [AW:0]   space;
  logic          admit;
  logic          wr_en;
  logic          pop;
  logic [AW-1:0] slot_a;
  logic [AW-1:0] slot_d;

  always_comb begin
    grp_n   = {1'b0, itm_valid} + {1'b0, atm_valid} + {1'b0, dtm_valid};
    grp_n_w = (AW+1)'(grp_n);
    // Space is judged on the start-of-cycle count; a same-cycle pop does not help.
    space   = DEPTH_W - cnt_q;
    admit   = (grp_n_w <= space);
    wr_en   = admit && !trc_clear;
    pop     = tr_valid && tr_ready;
    // Present messages pack into consecutive slots; absent ones take no slot.
    slot_a  = wp_q + AW'(itm_valid);
    slot_d  = slot_a + AW'(atm_valid);

    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (trc_clear) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (wr_en) begin
        wp_d = wp_q + AW'(grp_n);
      end
      if (pop) begin
        rp_d = rp_q + AW'(1);
      end
      cnt_d = cnt_q + (wr_en ? grp_n_w : '0) - (pop ? (AW+1)'(1) : '0);
      if ((grp_n != 2'd0) && !admit) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (itm_valid) mem_q[wp_q]   <= itm;
      if (atm_valid) mem_q[slot_a] <= atm;
      if (dtm_valid) mem_q[slot_d] <= dtm;
    end
  end

  assign tr_valid    = (cnt_q != '0);
  assign tr_data     = mem_q[rp_q];
  assign fifo_count  = cnt_q;
  assign tm_overflow = ovf_q;

endmodule

// File: doc/nios2_oci_tm_fifo_drain.md
Name: nios2_oci_tm_fifo_drain

Overview:
- Receive side of the OCI trace-message path.
- Each cycle, accepts 0-3 trace messages (instruction, address, data) in one group, whose size is the popcount of the three valids.
- Stores them in a circular buffer and drains them one per cycle to the trace output port using a valid/ready handshake.
- Sits between the per-cycle trace message generators and the off-chip trace/PIB serializer.

Parameters:
- DEPTH, 16, number of 36-bit entries; must be a power of 2 and >= 4.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- itm  input  36  instruction trace message.
- itm_valid  input  1  itm present this cycle.
- atm  input  36  address trace message.
- atm_valid  input  1  atm present this cycle.
- dtm  input  36  data trace message.
- dtm_valid  input  1  dtm present this cycle.
- trc_clear  input  1  synchronous flush of the buffer plus clear of the overflow flag.
- tr_data  output  36  head-of-buffer message.
- tr_valid  output  1  tr_data is valid.
- tr_ready  input  1  downstream accepts tr_data this cycle.
- fifo_count  output  AW+1  current occupancy, 0..DEPTH.
- tm_overflow  output  1  sticky flag: at least one message group was dropped.

Behaviour:
- Reset, async and active-high: write pointer = 0, read pointer = 0, fifo_count = 0, tm_overflow = 0, tr_valid = 0. tr_data is don't-care while tr_valid = 0.
- Storage contents are not reset.
- Group size n = itm_valid + atm_valid + dtm_valid, range 0..3.
- Write order within a group is fixed: itm, then atm, then dtm.
  - Absent messages are skipped, so the present ones occupy consecutive slots starting at the write pointer.
  - Example: {itm_valid, atm_valid, dtm_valid} = 101 writes itm at wp and dtm at wp+1.
- Pointers are AW bits wide and wrap modulo DEPTH. A group may straddle the wrap point.
- Admission:
  - A group is written only if n <= DEPTH - fifo_count, where fifo_count is the value at the start of the cycle. A read in the same cycle does not free space for that cycle's write.
  - Otherwise the whole group is dropped (no partial writes), tm_overflow is set, and the pointers and count are unchanged by the write.
- Read:
  - tr_valid = (fifo_count != 0).
  - tr_data = mem[read pointer], driven combinationally from storage.
  - A pop occurs when tr_valid & tr_ready.
  - While tr_valid = 0, tr_ready is ignored and there is no underflow.
- Latency: a message written at edge k is visible at tr_data/tr_valid after edge k; there is no same-cycle bypass.
- Count update: fifo_count_next = fifo_count + n_accepted - pop, with 0 <= fifo_count <= DEPTH always.
- Simultaneous write and pop:
  - Both take effect.
  - At full, a pop plus an n >= 1 group drops the group (see Admission). The pop still completes and tm_overflow is set.
- trc_clear:
  - Takes priority over write and pop in the same cycle.
  - Pointers and count go to 0; tm_overflow goes to 0.
  - That cycle's incoming group is discarded without setting overflow.
- tm_overflow stays set until trc_clear or reset. Later successful writes do not clear it.
- n = 0 with no pop: all state holds.

Test Plan:
- Ordering: reset, then one cycle with all three valids (itm=0x1, atm=0x2, dtm=0x3), tr_ready=1 from the next cycle -> tr_data reads 0x1, 0x2, 0x3 on consecutive cycles; fifo_count goes 3, 2, 1, 0; tr_valid falls after the third.
- Sparse group: valids 101 with itm=0xA, dtm=0xC -> exactly two entries, 0xA then 0xC; fifo_count = 2.
- Fill and overflow (DEPTH=16, tr_ready=0): five 3-message groups give fifo_count = 15. Then a 2-message group is dropped, fifo_count stays 15 and tm_overflow = 1. Then a 1-message group is accepted, fifo_count = 16.
- Full with simultaneous pop: at count 16 with tr_ready=1 and a 1-message group -> the group is dropped, one pop occurs, fifo_count = 15, tm_overflow = 1.
- Wrap-around: drain and refill continuously for 40 messages with a random tr_ready pattern -> the output sequence equals the input order exactly, including groups that straddle the wrap point; fifo_count matches a scoreboard every cycle.
- Clear and reset: with fifo_count = 7 and tm_overflow = 1, assert trc_clear together with a 3-message group -> next cycle fifo_count = 0, tm_overflow = 0, tr_valid = 0. Repeat with reset asserted mid-drain, asynchronously between clock edges -> outputs go to reset values immediately.
